serdes_clk_seq: RTL



---
 rtl/serdes_clk_pkg.sv | 33 +++
 rtl/serdes_clk_seq_if.sv | 22 ++
 rtl/serdes_clk_seq_sync_2ff.sv | 24 ++
 rtl/serdes_clk_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/serdes_clk_pkg.sv
// Shared definitions for the SERDES clock sequencer: state encodings,
// counter saturation limits and default cycle counts.
package serdes_clk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLL_RST    = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_SERDES_RST = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAIL       = 3'd6
  } state_e;

  localparam logic [2:0] RETRY_SAT = 3'd7;
  localparam logic [7:0] LOSS_SAT  = 8'd255;

  localparam int DEF_RST_HOLD_CYC     = 64;
  localparam int DEF_LOCK_TIMEOUT_CYC = 200000;
  localparam int DEF_SETTLE_CYC       = 1024;
  localparam int DEF_SERDES_RST_CYC   = 16;
  localparam int DEF_MAX_RETRY        = 7;
  localparam int DEF_CNT_W            = 20;

  function automatic logic [2:0] sat_inc_retry(input logic [2:0] v);
    return (v == RETRY_SAT) ? v : v + 3'd1;
  endfunction

  function automatic logic [7:0] sat_inc_loss(input logic [7:0] v);
    return (v == LOSS_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serdes_clk_seq_if.sv
// Control/status bundle between the PLL/SERDES clock sequencer and its user.
interface serdes_clk_seq_if;
  logic       en;
  logic       pll_locked_in;
  logic       pll_rst_out;
  logic       serdes_rst_out;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_out;

  modport master (
    output en, pll_locked_in,
    input  pll_rst_out, serdes_rst_out, ready, fail, retry_cnt, loss_cnt, state_out
  );

  modport slave (
    input  en, pll_locked_in,
    output pll_rst_out, serdes_rst_out, ready, fail, retry_cnt, loss_cnt, state_out
  );
endinterface

// File: rtl/serdes_clk_seq_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for single-bit level CDC paths.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  (* ASYNC_REG = "TRUE" *) logic r_meta;
  (* ASYNC_REG = "TRUE" *) logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/serdes_clk_seq.sv
// PLL power-up/recovery sequencer: PLL reset, lock wait with bounded retries,
// settle, SERDES reset pulse, then READY until lock is lost.
module serdes_clk_seq
  import serdes_clk_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int SETTLE_CYC       = DEF_SETTLE_CYC,
  parameter int SERDES_RST_CYC   = DEF_SERDES_RST_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic            i_clk,
  input  logic            i_rst,
  serdes_clk_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SRST_LAST    = CNT_W'(SERDES_RST_CYC - 1);

  state_e           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_timer, w_nxt_timer;
  logic [2:0]       r_retry, w_nxt_retry, w_retry_inc;
  logic [7:0]       r_loss, w_nxt_loss;
  logic             r_pll_rst, r_serdes_rst, r_ready, r_fail;
  logic             w_lk;

  sync_2ff #(.RST_VAL(1'b0)) u_lk_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.pll_locked_in),
    .o_q   (w_lk)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_retry = r_retry;
    w_nxt_loss  = r_loss;
    w_retry_inc = sat_inc_retry(r_retry);
    if (!bus.en) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nxt_state = ST_PLL_RST;
          w_nxt_retry = '0;
        end
        ST_PLL_RST:
          if (r_timer == HOLD_LAST) w_nxt_state = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (w_lk) begin
            w_nxt_state = ST_SETTLE;
          end else if (r_timer == TIMEOUT_LAST) begin
            w_nxt_retry = w_retry_inc;
            if (MAX_RETRY != 0 && int'(w_retry_inc) >= MAX_RETRY)
              w_nxt_state = ST_FAIL;
            else
              w_nxt_state = ST_PLL_RST;
          end
        // A lock drop while settling restarts the lock wait without costing a retry.
        ST_SETTLE:
          if (!w_lk)                      w_nxt_state = ST_WAIT_LOCK;
          else if (r_timer == SETTLE_LAST) w_nxt_state = ST_SERDES_RST;
        ST_SERDES_RST:
          if (!w_lk) begin
            w_nxt_state = ST_PLL_RST;
            w_nxt_loss  = sat_inc_loss(r_loss);
          end else if (r_timer == SRST_LAST) begin
            w_nxt_state = ST_RUN;
          end
        ST_RUN:
          if (!w_lk) begin
            w_nxt_state = ST_PLL_RST;
            w_nxt_loss  = sat_inc_loss(r_loss);
            w_nxt_retry = '0;
          end
        ST_FAIL: w_nxt_state = ST_FAIL;
        default: w_nxt_state = ST_IDLE;
      endcase
    end
    // Timer parks at zero in the two waiting-forever states so it cannot wrap.
    if (w_nxt_state != r_state || r_state == ST_IDLE || r_state == ST_FAIL)
      w_nxt_timer = '0;
    else
      w_nxt_timer = r_timer + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_retry      <= '0;
      r_loss       <= '0;
      r_pll_rst    <= 1'b1;
      r_serdes_rst <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_timer      <= w_nxt_timer;
      r_retry      <= w_nxt_retry;
      r_loss       <= w_nxt_loss;
      r_pll_rst    <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_PLL_RST) ||
                      (w_nxt_state == ST_FAIL);
      r_serdes_rst <= (w_nxt_state != ST_RUN);
      r_ready      <= (w_nxt_state == ST_RUN);
      r_fail       <= (w_nxt_state == ST_FAIL);
    end
  end

  assign bus.pll_rst_out    = r_pll_rst;
  assign bus.serdes_rst_out = r_serdes_rst;
  assign bus.ready          = r_ready;
  assign bus.fail           = r_fail;
  assign bus.retry_cnt      = r_retry;
  assign bus.loss_cnt       = r_loss;
  assign bus.state_out      = r_state;
endmodule
